wam_mol: RTL
============

Name: wam_mol

Overview:
- Mole-field controller for the whack-a-mole game.
- Consumes the hardness parameters (age = mole lifetime in game ticks, rto = spawn ratio) and the debounced touch pulses.
- Pops moles up pseudo-randomly, detects hits and expiries, and keeps a 2-digit BCD score.
- Emits cout0, a one-cycle pulse on every ones-digit wrap. cout0 feeds back into the hardness controller to raise difficulty every 10 hits.

Parameters:
- HOLES, 8, number of holes; power of two, 2..16.
- HW, 3, log2(HOLES), hole-index width.
- GAME_TICKS, 240, game length in ticks, 1..255.

Ports:
- clk_19  in  1  system clock.
- clr_n  in  1  asynchronous active-low reset.
- tick  in  1  one-cycle game-step enable from the prescaler.
- start  in  1  one-cycle pulse (debounced) that starts a game.
- age  in  4  mole lifetime in ticks; 0 is treated as 1.
- rto  in  8  spawn ratio; only bits [6:0] are used.
- tch  in  HOLES  debounced one-cycle touch pulses, one per hole.
- mole  out  HOLES  mole-up flags, drive LEDs.
- scr_lo  out  4  BCD ones digit.
- scr_hi  out  4  BCD tens digit.
- cout0  out  1  one-cycle pulse when scr_lo wraps 9->0.
- hit  out  1  one-cycle pulse per scored hit.
- miss  out  1  one-cycle pulse per expired mole.
- run  out  1  high in PLAY.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE; all outputs 0; life counters 0; tick counter 0.
  - LFSR = 16'hACE1.
  - Reset mid-game aborts immediately.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clk_19 cycle in all states, so start timing seeds randomness.
  - Never reaches 0.
- States:
  - IDLE: run=0, moles held 0. start -> PLAY, clears score and tick counter.
  - PLAY: run=1. On each tick, the tick counter increments. When the counter reaches GAME_TICKS-1 and a tick arrives -> OVER.
  - OVER: run=0, all moles cleared in the same edge, score frozen. start -> PLAY with score cleared.
- Spawn (PLAY, tick=1):
  - Spawn occurs when lfsr[6:0] < rto[6:0], i.e. probability rto/128.
  - Target hole = lfsr[HW+7:8].
  - If the target is already up, no spawn and no retry.
  - On spawn: mole[target]<=1, life[target]<=max(age,1).
- Ageing (PLAY, tick=1):
  - Every up hole except a just-spawned one decrements life.
  - A hole with life==1 goes down instead and pulses miss.
  - If several expire on the same tick, miss is a single pulse.
- Hit:
  - tch[i]=1 while mole[i]=1 -> mole[i]<=0, life[i]<=0, hit pulse, score+1 at the next edge.
  - Only the lowest-indexed qualifying hole is honoured per cycle; other touched moles stay up and may be hit later.
  - A touch on an empty hole is ignored (see Optional Feature).
  - Touches outside PLAY are ignored.
- Simultaneous events:
  - Hit and expiry on the same hole in the same cycle: hit wins, no miss.
  - Hit and spawn targeting the same hole in the same cycle: hole ends down (the spawn saw it up).
  - start during PLAY is ignored.
- Score:
  - BCD, 00..99, wraps 99->00.
  - Each scr_lo 9->0 wrap pulses cout0 on the same edge as the score update and increments scr_hi.
  - scr_hi 9->0 wraps silently.
- Latency: every input-to-output response is exactly one clk_19 edge; all outputs are registered.

Optional Feature:
- Macro: WAM_MISS_PENALTY_EN.
- Defined:
  - In PLAY, a tch on an empty hole (when no hit qualifies that cycle) decrements the score by 1, BCD borrow 10->09, saturating at 00.
  - Each mole expiry decrements the score by 1 likewise.
  - If a hit and a penalty coincide, the hit is applied and the penalty dropped.
  - cout0 never pulses on a decrement.
- Undefined: empty-hole touches are ignored and expiry only pulses miss.

Decomposition:
- Package wam_pkg:
  - state enum {IDLE, PLAY, OVER}.
  - LFSR_SEED=16'hACE1 and tap-mask constant.
  - BCD_MAX=4'd9.
- Sub-module wam_lfsr (clk_19, clr_n, 16-bit q output), instantiated once.
- Hole logic as a generate loop in wam_mol.

Test Plan:
1. Reset then start, rto=0, 50 ticks -> mole stays 0, score 00, run=1.
2. Force seed so lfsr[6:0]=5 and hole 3 is selected; rto=42, age=3 -> mole[3] up; 3 ticks later mole[3]=0 and one miss pulse.
3. Mole[3] up, tch[3] pulse -> mole[3]=0, hit=1 for one cycle, score 01. Same cycle as expiry tick -> hit, no miss.
4. Score 09, hit -> scr_lo=0, scr_hi=1, cout0=1 for exactly one cycle. Score 99, hit -> 00 with cout0.
5. GAME_TICKS=4: start, 4 ticks -> OVER, run=0, moles cleared, further tch leave score unchanged. start -> score 00, PLAY.
6. WAM_MISS_PENALTY_EN: score 10, tch on empty hole -> 09. Score 00, tch on empty hole -> stays 00. Without the macro, score stays 10.

Source files
------------

// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared state encoding and constants for the mole-field controller
package wam_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
endpackage

// File: rtl/wam_lfsr.sv
// rtl/wam_lfsr.sv - free-running 16-bit Fibonacci LFSR, shifts every cycle
module wam_lfsr
  import wam_pkg::*;
(
  input  logic        clk_19,
  input  logic        clr_n,
  output logic [15:0] q
);
  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
  end

  always_ff @(posedge clk_19 or negedge clr_n) begin
    if (!clr_n) q_q <= LFSR_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/wam_mol.sv
// rtl/wam_mol.sv - mole spawn/age/hit logic with BCD score; WAM_MISS_PENALTY_EN enables score penalties
module wam_mol
  import wam_pkg::*;
#(
  parameter int HOLES      = 8,
  parameter int HW         = 3,
  parameter int GAME_TICKS = 240
) (
  input  logic             clk_19,
  input  logic             clr_n,
  input  logic             tick,
  input  logic             start,
  input  logic [3:0]       age,
  input  logic [7:0]       rto,
  input  logic [HOLES-1:0] tch,
  output logic [HOLES-1:0] mole,
  output logic [3:0]       scr_lo,
  output logic [3:0]       scr_hi,
  output logic             cout0,
  output logic             hit,
  output logic             miss,
  output logic             run
);
  state_t           state_q, state_d;
  logic [15:0]      lfsr;
  logic [HOLES-1:0] mole_q, mole_d, hole_nxt, expire, cand, hit_oh;
  logic [3:0]       life_q [HOLES];
  logic [3:0]       life_d [HOLES];
  logic [3:0]       life_nxt [HOLES];
  logic [7:0]       tcnt_q, tcnt_d;
  logic [3:0]       lo_q, lo_d, hi_q, hi_d;
  logic             cout0_q, cout0_d, hit_q, hit_d, miss_q, miss_d, run_q, run_d;
  logic             playing, spawn_ok, last_tick;
  logic [HW-1:0]    target;
  logic [3:0]       age_eff;
  logic             unused_bits;

  wam_lfsr u_lfsr (
    .clk_19 (clk_19),
    .clr_n  (clr_n),
    .q      (lfsr)
  );

  assign playing   = (state_q == PLAY);
  assign cand      = playing ? (tch & mole_q) : '0;
  // Isolate the lowest set bit: only one hit is honoured per cycle.
  assign hit_oh    = cand & (~cand + HOLES'(1));
  assign spawn_ok  = playing && tick && (lfsr[6:0] < rto[6:0]);
  assign target    = lfsr[HW+7:8];
  assign age_eff   = (age == 4'd0) ? 4'd1 : age;
  assign last_tick = playing && tick && (tcnt_q == 8'(GAME_TICKS - 1));
  assign unused_bits = ^{rto[7], lfsr[15:HW+8], lfsr[7]};

  for (genvar i = 0; i < HOLES; i++) begin : g_hole
    logic       up_n;
    logic       exp_n;
    logic [3:0] life_n;

    always_comb begin
      up_n   = mole_q[i];
      life_n = life_q[i];
      exp_n  = 1'b0;
      if (mole_q[i]) begin
        if (hit_oh[i]) begin
          up_n   = 1'b0;
          life_n = 4'd0;
        end else if (playing && tick) begin
          if (life_q[i] == 4'd1) begin
            up_n   = 1'b0;
            life_n = 4'd0;
            exp_n  = 1'b1;
          end else begin
            life_n = life_q[i] - 4'd1;
          end
        end
      end else if (spawn_ok && (target == HW'(i))) begin
        up_n   = 1'b1;
        life_n = age_eff;
      end
    end

    assign hole_nxt[i] = up_n;
    assign expire[i]   = exp_n;
    assign life_nxt[i] = life_n;
  end

  always_comb begin
    state_d = state_q;
    mole_d  = mole_q;
    life_d  = life_q;
    tcnt_d  = tcnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cout0_d = 1'b0;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = PLAY;
          tcnt_d  = 8'd0;
          lo_d    = 4'd0;
          hi_d    = 4'd0;
        end
      end
      PLAY: begin
        mole_d = hole_nxt;
        life_d = life_nxt;
        hit_d  = |hit_oh;
        miss_d = |expire;
        if (tick) tcnt_d = tcnt_q + 8'd1;
        if (|hit_oh) begin
          if (lo_q == BCD_MAX) begin
            lo_d    = 4'd0;
            cout0_d = 1'b1;
            hi_d    = (hi_q == BCD_MAX) ? 4'd0 : hi_q + 4'd1;
          end else begin
            lo_d = lo_q + 4'd1;
          end
        end
`ifdef WAM_MISS_PENALTY_EN
        else if ((|tch) || (|expire)) begin
          if (lo_q != 4'd0) begin
            lo_d = lo_q - 4'd1;
          end else if (hi_q != 4'd0) begin
            lo_d = BCD_MAX;
            hi_d = hi_q - 4'd1;
          end
        end
`endif
        if (last_tick) begin
          state_d = OVER;
          mole_d  = '0;
          for (int k = 0; k < HOLES; k++) life_d[k] = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == PLAY);
  end

  always_ff @(posedge clk_19 or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mole_q  <= '0;
      for (int k = 0; k < HOLES; k++) life_q[k] <= 4'd0;
      tcnt_q  <= 8'd0;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      cout0_q <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mole_q  <= mole_d;
      life_q  <= life_d;
      tcnt_q  <= tcnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cout0_q <= cout0_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      run_q   <= run_d;
    end
  end

  assign mole   = mole_q;
  assign scr_lo = lo_q;
  assign scr_hi = hi_q;
  assign cout0  = cout0_q;
  assign hit    = hit_q;
  assign miss   = miss_q;
  assign run    = run_q;
endmodule
